// File: rtl/add_chk_pkg.sv
// add_chk_pkg
// Shared types and constants for the adder result checker.
//   chk_state_e  : checker state machine encoding
//   DEF_DATA_W   : default operand/result width
//   DEF_CNT_W    : default counter/index width
//   MAX_LATENCY  : deepest supported BFM result latency
//   dly_entry_t  : layout of one delay-line entry at the default widths
package add_chk_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CNT_W   = 32;
  localparam int MAX_LATENCY = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  // Parameterized builds carry the same fields flattened as {exp, idx}
  // alongside the separate valid bit of the delay line.
  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] exp;
    logic [DEF_CNT_W-1:0]  idx;
  } dly_entry_t;

endpackage

// File: rtl/add_chk_delay.sv
// add_chk_delay
// Fixed-depth valid/data shift register; advances every cycle, no stall.
// An entry loaded at edge N is presented on the outputs after edge N+DEPTH-1,
// so a consumer sampling the outputs sees it at edge N+DEPTH.
// Ports:
//   clk_i       : clock, rising edge
//   reset_i     : synchronous active-high reset, clears valids and data
//   in_valid_i  : load a valid entry this cycle
//   in_data_i   : entry payload
//   out_valid_o : head entry valid
//   out_data_o  : head entry payload
module add_chk_delay
  import add_chk_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int WIDTH = DEF_DATA_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];

  // Shift valid and payload one stage per clock; stage 0 takes the new entry.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        data_r[i]  <= '0;
      end
    end else begin
      valid_r[0] <= in_valid_i;
      data_r[0]  <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        data_r[i]  <= data_r[i-1];
      end
    end
  end

  assign out_valid_o = valid_r[DEPTH-1];
  assign out_data_o  = data_r[DEPTH-1];

endmodule

// File: rtl/add_res_checker.sv
// add_res_checker
// Result checker placed beside the adder BFM. Computes (a+b) mod 2^DATA_W
// from the operand stream, delays it by LATENCY cycles, compares it with
// the BFM result and keeps pass/error statistics until LENGTH compares.
// Optional build macro: ADD_CHK_STOP_ON_ERR_EN -- first mismatch ends the run.
// Ports:
//   clk_i           : clock, rising edge
//   reset_i         : synchronous active-high reset
//   in_valid_i      : a_i/b_i carry a real transaction
//   a_i, b_i        : operands (also driven to the BFM)
//   res_i           : BFM result
//   pass_cnt_o      : matching compares (saturating)
//   err_cnt_o       : mismatching compares (saturating)
//   first_err_idx_o : transaction index of first mismatch, all-ones if none
//   err_o           : sticky, any mismatch seen
//   done_o          : sticky, run complete
module add_res_checker
  import add_chk_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LATENCY = 1,
  parameter int LENGTH  = 2000000,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] res_i,
  output logic [CNT_W-1:0]  pass_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic [CNT_W-1:0]  first_err_idx_o,
  output logic              err_o,
  output logic              done_o
);

  generate
    if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("add_res_checker: LATENCY must be within 1..16");
    end
  endgenerate

  localparam int               ENT_W  = DATA_W + CNT_W;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] MAX_C  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == MAX_C) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  chk_state_e        state_r;
  chk_state_e        state_nx_s;
  logic [CNT_W-1:0]  issue_cnt_r;
  logic [CNT_W-1:0]  check_cnt_r;
  logic [CNT_W-1:0]  pass_cnt_r;
  logic [CNT_W-1:0]  err_cnt_r;
  logic [CNT_W-1:0]  first_err_idx_r;
  logic              err_r;
  logic              done_r;

  logic [DATA_W-1:0] exp_s;
  logic              push_s;
  logic              head_valid_s;
  logic [ENT_W-1:0]  head_data_s;
  logic [DATA_W-1:0] head_exp_s;
  logic [CNT_W-1:0]  head_idx_s;
  logic              cmp_s;
  logic              mismatch_s;
  logic              stop_s;
  logic              last_push_s;
  logic              last_chk_s;

  // Carry out of the add is dropped by the DATA_W-wide target.
  assign exp_s = a_i + b_i;

  // Nothing is accepted after LENGTH issues or once the run has ended.
  assign push_s = in_valid_i && (issue_cnt_r < LEN_C) && (state_r != DONE);

  add_chk_delay #(
    .DEPTH (LATENCY),
    .WIDTH (ENT_W)
  ) u_delay (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (push_s),
    .in_data_i   ({exp_s, issue_cnt_r}),
    .out_valid_o (head_valid_s),
    .out_data_o  (head_data_s)
  );

  assign head_exp_s  = head_data_s[ENT_W-1 -: DATA_W];
  assign head_idx_s  = head_data_s[CNT_W-1:0];
  assign cmp_s       = head_valid_s && ((state_r == RUN) || (state_r == DRAIN));
  assign mismatch_s  = cmp_s && (res_i != head_exp_s);
  assign last_push_s = push_s && (issue_cnt_r == LAST_C);
  assign last_chk_s  = cmp_s && (check_cnt_r == LAST_C);

`ifdef ADD_CHK_STOP_ON_ERR_EN
  assign stop_s = mismatch_s;
`else
  assign stop_s = 1'b0;
`endif

  // Next-state decode; a single-transaction run goes straight to DRAIN.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (push_s) begin
          if (last_push_s) begin
            state_nx_s = DRAIN;
          end else begin
            state_nx_s = RUN;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (stop_s) begin
          state_nx_s = DONE;
        end else if (last_push_s) begin
          state_nx_s = DRAIN;
        end else begin
          state_nx_s = RUN;
        end
      end
      DRAIN: begin
        if (stop_s || last_chk_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = DRAIN;
        end
      end
      DONE:    state_nx_s = DONE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Issue/check indices, result statistics and sticky flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_cnt_r     <= '0;
      check_cnt_r     <= '0;
      pass_cnt_r      <= '0;
      err_cnt_r       <= '0;
      first_err_idx_r <= '1;
      err_r           <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      if (push_s) begin
        issue_cnt_r <= sat_inc(issue_cnt_r);
      end
      if (cmp_s) begin
        check_cnt_r <= sat_inc(check_cnt_r);
        if (mismatch_s) begin
          err_cnt_r <= sat_inc(err_cnt_r);
          err_r     <= 1'b1;
          if (err_cnt_r == '0) begin
            first_err_idx_r <= head_idx_s;
          end
        end else begin
          pass_cnt_r <= sat_inc(pass_cnt_r);
        end
      end
      if (state_nx_s == DONE) begin
        done_r <= 1'b1;
      end
    end
  end

  assign pass_cnt_o      = pass_cnt_r;
  assign err_cnt_o       = err_cnt_r;
  assign first_err_idx_o = first_err_idx_r;
  assign err_o           = err_r;
  assign done_o          = done_r;

endmodule
